// File: rtl/color_bbox_detect_if.sv
// color_bbox_detect_if: pixel stream in/out plus latched bounding-box results.
interface color_bbox_detect_if;
    logic        pre_vs;
    logic        pre_hs;
    logic        pre_clken;
    logic [15:0] pre_img_data;
    logic        post_vs;
    logic        post_hs;
    logic        post_clken;
    logic [15:0] post_img_data;
    logic [10:0] box_x_min;
    logic [10:0] box_x_max;
    logic [9:0]  box_y_min;
    logic [9:0]  box_y_max;
    logic        box_valid;
    logic        box_update;

    modport master (
        output pre_vs, pre_hs, pre_clken, pre_img_data,
        input  post_vs, post_hs, post_clken, post_img_data,
        input  box_x_min, box_x_max, box_y_min, box_y_max, box_valid, box_update
    );
    modport slave (
        input  pre_vs, pre_hs, pre_clken, pre_img_data,
        output post_vs, post_hs, post_clken, post_img_data,
        output box_x_min, box_x_max, box_y_min, box_y_max, box_valid, box_update
    );
endinterface

// File: rtl/color_bbox_detect.sv
// color_bbox_detect: RGB565 colour-window bounding box per frame, drawn onto the next frame.
module color_bbox_detect #(
    parameter int          IMG_W     = 640,
    parameter int          IMG_H     = 480,
    parameter int          R_LO      = 20,
    parameter int          R_HI      = 31,
    parameter int          G_LO      = 0,
    parameter int          G_HI      = 20,
    parameter int          B_LO      = 0,
    parameter int          B_HI      = 12,
    parameter int          MIN_PIX   = 64,
    parameter logic [15:0] BOX_COLOR = 16'h07E0
) (
    input logic               clk,
    input logic               rst,
    color_bbox_detect_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACTIVE, LATCH} state_t;
    state_t state, nxt;
    logic vs_d, hs_d;
    logic [10:0] x_cnt, acc_xmin, acc_xmax;
    logic [9:0] y_cnt, acc_ymin, acc_ymax;
    logic [19:0] hit_cnt;
    logic qual, vs_rise, vs_fall, hs_fall, hit, init, on_box;
    logic [4:0] r, b;
    logic [5:0] g;

    assign r = bus.pre_img_data[15:11];
    assign g = bus.pre_img_data[10:5];
    assign b = bus.pre_img_data[4:0];
    assign qual = bus.pre_vs && bus.pre_hs && bus.pre_clken;
    assign vs_rise = bus.pre_vs && !vs_d;
    assign vs_fall = !bus.pre_vs && vs_d;
    assign hs_fall = !bus.pre_hs && hs_d;
    assign hit = qual && int'(x_cnt) < IMG_W && int'(y_cnt) < IMG_H
              && int'(r) >= R_LO && int'(r) <= R_HI
              && int'(g) >= G_LO && int'(g) <= G_HI
              && int'(b) >= B_LO && int'(b) <= B_HI;
    assign init = nxt == ACTIVE && state != ACTIVE;
    assign on_box = bus.box_valid && qual
        && (((x_cnt == bus.box_x_min || x_cnt == bus.box_x_max)
             && y_cnt >= bus.box_y_min && y_cnt <= bus.box_y_max)
         || ((y_cnt == bus.box_y_min || y_cnt == bus.box_y_max)
             && x_cnt >= bus.box_x_min && x_cnt <= bus.box_x_max));

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = vs_rise ? ACTIVE : IDLE;
            ACTIVE:  nxt = vs_fall ? LATCH : ACTIVE;
            default: nxt = vs_rise ? ACTIVE : IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= IDLE;
        else
            state <= nxt;

    // vs_d resets high so a reset released mid-frame is not mistaken for a frame start
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            vs_d  <= 1'b1;
            hs_d  <= 1'b0;
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            vs_d <= bus.pre_vs;
            hs_d <= bus.pre_hs;
            if (hs_fall)
                x_cnt <= '0;
            else if (qual && x_cnt != '1)
                x_cnt <= x_cnt + 1'b1;
            if (vs_rise)
                y_cnt <= '0;
            else if (hs_fall && bus.pre_vs && y_cnt != '1)
                y_cnt <= y_cnt + 1'b1;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst || init) begin
            acc_xmin <= '1;
            acc_xmax <= '0;
            acc_ymin <= '1;
            acc_ymax <= '0;
            hit_cnt  <= '0;
        end else if (state == ACTIVE && hit) begin
            acc_xmin <= x_cnt < acc_xmin ? x_cnt : acc_xmin;
            acc_xmax <= x_cnt > acc_xmax ? x_cnt : acc_xmax;
            acc_ymin <= y_cnt < acc_ymin ? y_cnt : acc_ymin;
            acc_ymax <= y_cnt > acc_ymax ? y_cnt : acc_ymax;
            hit_cnt  <= hit_cnt != '1 ? hit_cnt + 1'b1 : hit_cnt;
        end

    // Box registers load on entry to LATCH so they are already valid while box_update is high
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            bus.box_x_min  <= '0;
            bus.box_x_max  <= '0;
            bus.box_y_min  <= '0;
            bus.box_y_max  <= '0;
            bus.box_valid  <= 1'b0;
            bus.box_update <= 1'b0;
        end else begin
            bus.box_update <= nxt == LATCH;
            if (nxt == LATCH) begin
                bus.box_x_min <= acc_xmin;
                bus.box_x_max <= acc_xmax;
                bus.box_y_min <= acc_ymin;
                bus.box_y_max <= acc_ymax;
                bus.box_valid <= int'(hit_cnt) >= MIN_PIX;
            end
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            bus.post_vs       <= 1'b0;
            bus.post_hs       <= 1'b0;
            bus.post_clken    <= 1'b0;
            bus.post_img_data <= '0;
        end else begin
            bus.post_vs       <= bus.pre_vs;
            bus.post_hs       <= bus.pre_hs;
            bus.post_clken    <= bus.pre_clken;
            bus.post_img_data <= on_box ? BOX_COLOR : bus.pre_img_data;
        end
endmodule

// File: tb/tb_color_bbox_detect.sv
// tb_color_bbox_detect: directed frames on an 8x4 image; scoreboard queues checked by a negedge monitor.
module tb_color_bbox_detect;
    typedef struct {int cyc; logic [15:0] d;} pix_t;
    typedef struct {logic [10:0] x0, x1; logic [9:0] y0, y1; logic v;} box_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    pix_t pq[$];
    box_t bq[$];
    bit ov_v = 0;
    int ox0, ox1, oy0, oy1;
    logic [2:0] last_sync = '0;
    bit last_ok = 0;

    always #5 clk = ~clk;

    color_bbox_detect_if bus();
    color_bbox_detect #(.IMG_W(8), .IMG_H(4), .MIN_PIX(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
        end
    endtask

    function automatic logic [15:0] pix(input int mode, input int x, input int y);
        case (mode)
            1: return (x >= 2 && x <= 4 && y >= 1 && y <= 2) ? 16'hF800 : 16'h0000;
            2: return (y == 1 && x == 2) ? 16'hA000 : (y == 1 && x == 3) ? 16'hFA8C :
                      (y == 1 && x == 4) ? 16'hF800 : (y == 0 && x == 0) ? 16'hFAA0 :
                      (y == 2 && x == 6) ? 16'h9800 : (y == 3 && x == 5) ? 16'hF80D : 16'h0000;
            3: return (x == 9 || (x == 1 && y == 3)) ? 16'hF800 : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic bit border(input int x, input int y);
        return ov_v && (((x == ox0 || x == ox1) && y >= oy0 && y <= oy1)
                     || ((y == oy0 || y == oy1) && x >= ox0 && x <= ox1));
    endfunction

    task automatic set_ov(input bit v, input int x0, input int x1, input int y0, input int y1);
        ov_v = v; ox0 = x0; ox1 = x1; oy0 = y0; oy1 = y1;
    endtask

    task automatic exp_box(input int x0, input int x1, input int y0, input int y1, input bit v);
        bq.push_back('{11'(x0), 11'(x1), 10'(y0), 10'(y1), v});
    endtask

    task automatic drive(input logic vs, input logic hs, input logic ck, input logic [15:0] d,
                         input int x, input int y);
        @(posedge clk);
        #1;
        bus.pre_vs = vs;
        bus.pre_hs = hs;
        bus.pre_clken = ck;
        bus.pre_img_data = d;
        if (ck)
            pq.push_back('{cyc + 1, (vs && hs && border(x, y)) ? 16'h07E0 : d});
    endtask

    task automatic frame(input int mode, input int n, input int y0, input int y1,
                         input bit start, input bit fin, input int tail);
        if (start)
            drive(1, 0, 0, 16'h0, 0, 0);
        for (int y = y0; y < y1; y++) begin
            drive(1, 1, 0, 16'hF800, 0, y);
            for (int x = 0; x < n; x++)
                drive(1, 1, 1, pix(mode, x, y), x, y);
            drive(1, 0, 0, 16'h0, 0, y);
            drive(1, 0, 0, 16'h0, 0, y);
        end
        if (fin)
            drive(0, 0, 0, 16'h0, 0, 0);
        repeat (tail) drive(0, 0, 0, 16'h0, 0, 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (last_ok)
                chk("sync_lag", {bus.post_vs, bus.post_hs, bus.post_clken}, last_sync);
            if (bus.post_clken) begin
                if (pq.size() == 0)
                    chk("pix_unexpected", 1, 0);
                else begin
                    chk("pix_cycle", cyc, pq[0].cyc);
                    chk("pix_data", bus.post_img_data, pq[0].d);
                    void'(pq.pop_front());
                end
            end
            if (bus.box_update) begin
                if (bq.size() == 0)
                    chk("box_unexpected", 1, 0);
                else begin
                    chk("box_x_min", bus.box_x_min, bq[0].x0);
                    chk("box_x_max", bus.box_x_max, bq[0].x1);
                    chk("box_y_min", bus.box_y_min, bq[0].y0);
                    chk("box_y_max", bus.box_y_max, bq[0].y1);
                    chk("box_valid", bus.box_valid, bq[0].v);
                    void'(bq.pop_front());
                end
            end
        end
        last_ok <= !rst;
        last_sync <= {bus.pre_vs, bus.pre_hs, bus.pre_clken};
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pre_vs = 0;
        bus.pre_hs = 0;
        bus.pre_clken = 0;
        bus.pre_img_data = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_box_x_min", bus.box_x_min, 0);
        chk("rst_box_x_max", bus.box_x_max, 0);
        chk("rst_box_y_min", bus.box_y_min, 0);
        chk("rst_box_y_max", bus.box_y_max, 0);
        chk("rst_box_valid", bus.box_valid, 0);
        chk("rst_box_update", bus.box_update, 0);
        chk("rst_post_sync", {bus.post_vs, bus.post_hs, bus.post_clken}, 0);
        chk("rst_post_data", bus.post_img_data, 0);
        @(posedge clk);
        #1 rst = 0;
        // red block, no prior box
        exp_box(2, 4, 1, 2, 1);
        frame(1, 8, 0, 4, 1, 1, 3);
        // blank frame carries the green overlay of the previous box
        set_ov(1, 2, 4, 1, 2);
        exp_box(2047, 0, 1023, 0, 0);
        frame(0, 8, 0, 4, 1, 1, 3);
        // three boundary-colour hits plus near misses
        set_ov(0, 0, 0, 0, 0);
        exp_box(2, 4, 1, 1, 0);
        frame(2, 8, 0, 4, 1, 1, 3);
        // 10 pixels per line, red beyond IMG_W, one hit at (1,3)
        exp_box(1, 1, 3, 3, 0);
        frame(3, 10, 0, 4, 1, 1, 3);
        exp_box(2, 4, 1, 2, 1);
        frame(1, 8, 0, 4, 1, 1, 3);
        // mid-frame reset discards the frame
        set_ov(1, 2, 4, 1, 2);
        frame(1, 8, 0, 2, 1, 0, 0);
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        set_ov(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("mid_rst_box_valid", bus.box_valid, 0);
        chk("mid_rst_box_x_max", bus.box_x_max, 0);
        chk("mid_rst_box_update", bus.box_update, 0);
        frame(1, 8, 2, 4, 0, 1, 3);
        // full frame, then the next one starts in the LATCH cycle
        exp_box(2, 4, 1, 2, 1);
        frame(1, 8, 0, 4, 1, 1, 0);
        set_ov(1, 2, 4, 1, 2);
        exp_box(2, 4, 1, 1, 0);
        frame(2, 8, 0, 4, 1, 1, 3);
        repeat (4) @(negedge clk);
        chk("hold_box_x_min", bus.box_x_min, 2);
        chk("hold_box_x_max", bus.box_x_max, 4);
        chk("hold_box_y_min", bus.box_y_min, 1);
        chk("hold_box_y_max", bus.box_y_max, 1);
        chk("hold_box_valid", bus.box_valid, 0);
        chk("pix_queue_drained", pq.size(), 0);
        chk("box_queue_drained", bq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
